// File: rtl/atm_session_timer.sv
// Multi-channel ATM session/inactivity timer sharing one clock prescaler.
// Latency: count/timeout/timeout_pulse update on the edge that samples tick; warn and any_timeout are combinational.
// Backpressure: none; kick/ack/enable are level inputs that are acted on every cycle.
//
// Ports:
//   i_clk, i_rst          rising-edge clock, synchronous active-high reset
//   i_enable[NUM_CH]      channel run; low forces the channel to IDLE and clears it
//   i_kick[NUM_CH]        user activity; restarts the channel count from 0
//   i_ack[NUM_CH]         clears the sticky timeout flag
//   i_auto_reload[NUM_CH] 1 = periodic, 0 = one-shot; latched at arm/kick
//   i_limit               per-channel timeout in ticks, latched at arm/kick (0 treated as 1)
//   i_warn_lvl            per-channel warning level in ticks (0 = off), used live
//   o_tick                one-cycle prescaler strobe
//   o_count               elapsed ticks per channel
//   o_warn                channel running and count >= warn level
//   o_timeout_pulse       one-cycle strobe on each expiry
//   o_timeout             sticky expiry flag
//   o_any_timeout         OR of o_timeout
module atm_session_timer #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_enable,
    input  logic [NUM_CH-1:0]       i_kick,
    input  logic [NUM_CH-1:0]       i_ack,
    input  logic [NUM_CH-1:0]       i_auto_reload,
    input  logic [NUM_CH*CNT_W-1:0] i_limit,
    input  logic [NUM_CH*CNT_W-1:0] i_warn_lvl,
    output logic                    o_tick,
    output logic [NUM_CH*CNT_W-1:0] o_count,
    output logic [NUM_CH-1:0]       o_warn,
    output logic [NUM_CH-1:0]       o_timeout_pulse,
    output logic [NUM_CH-1:0]       o_timeout,
    output logic                    o_any_timeout
);

    localparam int              PW     = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0]   LP_TOP = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Shared prescaler. The tick flop is loaded with the compare of the
    // *next* prescaler value, so o_tick is high exactly during the cycle
    // in which the prescaler holds PRESCALE-1. With PRESCALE=1 the next
    // value is always 0 == LP_TOP and tick stays high after reset.
    // ------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          r_tick;

    always_comb begin
        w_presc_nxt = (r_presc == LP_TOP) ? '0 : r_presc + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= (w_presc_nxt == LP_TOP);
        end
    end

    assign o_tick = r_tick;

    // ------------------------------------------------------------------
    // Per-channel FSMs. Each channel owns its registers inside its own
    // generate scope so channels share nothing but r_tick.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_count;
        logic [CNT_W-1:0] r_limit_q;
        logic             r_mode_q;
        logic             r_pulse;
        logic             r_timeout;

        logic [CNT_W-1:0] w_lim_in;
        logic [CNT_W-1:0] w_lim_lat;
        logic [CNT_W-1:0] w_wl;
        logic [CNT_W:0]   w_inc;
        logic             w_hit;

        assign w_lim_in  = i_limit[g*CNT_W +: CNT_W];
        assign w_wl      = i_warn_lvl[g*CNT_W +: CNT_W];
        // A zero limit would never match count+1, so it is treated as 1.
        assign w_lim_lat = (w_lim_in == '0) ? CNT_W'(1) : w_lim_in;
        // One extra bit keeps the compare exact when limit_q is all-ones.
        assign w_inc     = {1'b0, r_count} + (CNT_W+1)'(1);
        assign w_hit     = (w_inc == {1'b0, r_limit_q});

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state   <= ST_IDLE;
                r_count   <= '0;
                r_limit_q <= CNT_W'(1);
                r_mode_q  <= 1'b0;
                r_pulse   <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                // ack clears first; an expiry later in this block overrides
                // it, so a coincident set wins.
                if (i_ack[g]) begin
                    r_timeout <= 1'b0;
                end

                if (!i_enable[g]) begin
                    r_state   <= ST_IDLE;
                    r_count   <= '0;
                    r_timeout <= 1'b0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_state   <= ST_RUN;
                            r_count   <= '0;
                            r_limit_q <= w_lim_lat;
                            r_mode_q  <= i_auto_reload[g];
                        end

                        ST_RUN: begin
                            if (i_kick[g]) begin
                                // Kick outranks a coincident tick.
                                r_count   <= '0;
                                r_limit_q <= w_lim_lat;
                                r_mode_q  <= i_auto_reload[g];
                            end else if (r_tick) begin
                                if (w_hit) begin
                                    r_pulse   <= 1'b1;
                                    r_timeout <= 1'b1;
                                    if (r_mode_q) begin
                                        r_count <= '0;
                                    end else begin
                                        r_state <= ST_EXPIRED;
                                        r_count <= r_limit_q;
                                    end
                                end else begin
                                    r_count <= w_inc[CNT_W-1:0];
                                end
                            end
                        end

                        ST_EXPIRED: begin
                            // Count stays parked at the limit until re-armed.
                            if (i_kick[g]) begin
                                r_state   <= ST_RUN;
                                r_count   <= '0;
                                r_limit_q <= w_lim_lat;
                                r_mode_q  <= i_auto_reload[g];
                            end
                        end

                        default: begin
                            r_state <= ST_IDLE;
                            r_count <= '0;
                        end
                    endcase
                end
            end
        end

        assign o_count[g*CNT_W +: CNT_W] = r_count;
        assign o_timeout_pulse[g]        = r_pulse;
        assign o_timeout[g]              = r_timeout;
        // Warning follows warn_lvl live so software can move it mid-session.
        assign o_warn[g] = (r_state == ST_RUN) && (w_wl != '0) && (r_count >= w_wl);
    end

    assign o_any_timeout = |o_timeout;

endmodule

// File: tb/tb_atm_session_timer.sv
module tb_atm_session_timer;

    logic        clk;
    logic        rst;
    logic [1:0]  enable, kick, ack, auto_reload;
    logic [15:0] limit, warn_lvl;
    logic        tick;
    logic [15:0] count;
    logic [1:0]  warn, pulse, timeout;
    logic        any_to;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    atm_session_timer #(.NUM_CH(2), .CNT_W(8), .PRESCALE(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_kick         (kick),
        .i_ack          (ack),
        .i_auto_reload  (auto_reload),
        .i_limit        (limit),
        .i_warn_lvl     (warn_lvl),
        .o_tick         (tick),
        .o_count        (count),
        .o_warn         (warn),
        .o_timeout_pulse(pulse),
        .o_timeout      (timeout),
        .o_any_timeout  (any_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en0;
        logic       kick0;
        logic       ack0;
        logic [7:0] lim0;
        logic [7:0] wl0;
        logic       e_tick;
        logic [7:0] e_cnt;
        logic       e_warn;
        logic       e_pulse;
        logic       e_to;
    } vec_t;

    function automatic vec_t mk(input logic en0, input logic kick0, input logic ack0,
                                input logic [7:0] lim0, input logic [7:0] wl0,
                                input logic e_tick, input logic [7:0] e_cnt,
                                input logic e_warn, input logic e_pulse, input logic e_to);
        vec_t v;
        v.en0 = en0; v.kick0 = kick0; v.ack0 = ack0; v.lim0 = lim0; v.wl0 = wl0;
        v.e_tick = e_tick; v.e_cnt = e_cnt; v.e_warn = e_warn; v.e_pulse = e_pulse; v.e_to = e_to;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_pulse(input int ch, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pulse[ch]) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    vec_t vt[17];

    initial begin
        int  since, pulses, ticks, bad, t0, t1, t2, c1, warn_cnt, prev_tick;
        bit  ok, seen, prev_warn;

        // Edges are numbered from 1 = first edge with rst low. Ticks are
        // sampled by the channels at edges 4, 8, 12, 16 ...
        // ch0 armed at edge 1 with limit 3, warn 2, one-shot.
        vt[0]  = mk(1,0,0,3,2, 0,0,0,0,0);
        vt[1]  = mk(1,0,0,3,2, 0,0,0,0,0);
        vt[2]  = mk(1,0,0,3,2, 1,0,0,0,0);
        vt[3]  = mk(1,0,0,3,2, 0,1,0,0,0);
        vt[4]  = mk(1,0,0,3,2, 0,1,0,0,0);
        vt[5]  = mk(1,0,0,3,2, 0,1,0,0,0);
        vt[6]  = mk(1,0,0,3,2, 1,1,0,0,0);
        vt[7]  = mk(1,0,0,3,2, 0,2,1,0,0);
        vt[8]  = mk(1,0,0,3,2, 0,2,1,0,0);
        vt[9]  = mk(1,0,0,3,2, 0,2,1,0,0);
        vt[10] = mk(1,0,0,3,2, 1,2,1,0,0);
        vt[11] = mk(1,0,0,3,2, 0,3,0,1,1);   // expiry 11 cycles after arm
        vt[12] = mk(1,0,0,3,2, 0,3,0,0,1);
        vt[13] = mk(1,0,1,3,2, 0,3,0,0,0);   // ack clears
        vt[14] = mk(1,1,0,3,2, 1,0,0,0,0);   // kick re-arms from EXPIRED
        vt[15] = mk(1,0,0,3,2, 0,1,0,0,0);
        vt[16] = mk(0,0,0,3,2, 0,0,0,0,0);   // disable clears

        rst = 1'b1; enable = '0; kick = '0; ack = '0; auto_reload = '0;
        limit = '0; warn_lvl = '0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_tick", tick, 0);
        chk("rst_count", count, 0);
        chk("rst_warn", warn, 0);
        chk("rst_pulse", pulse, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_any", any_to, 0);

        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 17; i++) begin
            enable   = {1'b0, vt[i].en0};
            kick     = {1'b0, vt[i].kick0};
            ack      = {1'b0, vt[i].ack0};
            limit    = {8'd0, vt[i].lim0};
            warn_lvl = {8'd0, vt[i].wl0};
            step();
            chk($sformatf("v%0d_tick", i), tick, vt[i].e_tick);
            chk($sformatf("v%0d_cnt0", i), count[7:0], vt[i].e_cnt);
            chk($sformatf("v%0d_warn0", i), warn[0], vt[i].e_warn);
            chk($sformatf("v%0d_pulse0", i), pulse[0], vt[i].e_pulse);
            chk($sformatf("v%0d_to0", i), timeout[0], vt[i].e_to);
            chk($sformatf("v%0d_any", i), any_to, vt[i].e_to);
            chk($sformatf("v%0d_cnt1", i), count[15:8], 0);
        end

        // Tick cadence: exactly 1-in-4 over 40 cycles.
        ticks = 0; bad = 0; prev_tick = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick) begin
                ticks++;
                if (prev_tick >= 0 && cyc - prev_tick != 4) bad++;
                prev_tick = cyc;
            end
        end
        chk("tick_count_40", ticks, 10);
        chk("tick_spacing_bad", bad, 0);

        // Kick every 3 ticks, limit 5: never expires.
        enable = 2'b01; limit = 16'd5; warn_lvl = '0; auto_reload = '0; kick = '0;
        step();
        since = 0; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (since == 3) begin
                kick[0] = 1'b1; since = 0;
            end else begin
                kick[0] = 1'b0;
                if (tick) since++;
            end
            step();
            if (pulse[0]) pulses++;
        end
        kick[0] = 1'b1;
        step();
        kick[0] = 1'b0;
        chk("kick_no_pulse", pulses, 0);
        since = 0; ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (tick) since++;
            step();
            if (pulse[0]) begin ok = 1'b1; break; end
        end
        chk("kick_expiry_seen", ok, 1);
        chk("kick_ticks_to_expiry", since, 5);
        chk("kick_cnt_held", count[7:0], 5);
        chk("kick_to0", timeout[0], 1);

        // Warning with level 2, limit 4.
        enable = 2'b00; step();
        chk("dis_clears_to0", timeout[0], 0);
        enable = 2'b01; limit = 16'd4; warn_lvl = 16'd2;
        step();
        seen = 1'b0; ok = 1'b0; prev_warn = 1'b0; bad = 0;
        for (int c = 0; c < 40; c++) begin
            prev_warn = warn[0];
            step();
            if (warn[0] && !seen) begin
                seen = 1'b1;
                chk("warn_rise_cnt", count[7:0], 2);
            end
            if (warn[0] && count[7:0] < 2) bad++;
            if (pulse[0]) begin
                ok = 1'b1;
                chk("warn_before_expiry", prev_warn, 1);
                chk("warn_fall_at_expiry", warn[0], 0);
                break;
            end
        end
        chk("warn_expiry_seen", ok, 1);
        chk("warn_early_bad", bad, 0);

        // warn_lvl = 0 disables the warning.
        enable = 2'b00; step();
        enable = 2'b01; warn_lvl = '0;
        warn_cnt = 0;
        wait_pulse(0, t0, ok);
        for (int c = 0; c < 4; c++) begin
            if (warn[0]) warn_cnt++;
            step();
        end
        chk("wl0_expiry_seen", ok, 1);
        chk("wl0_warn_never", warn_cnt + warn[0], 0);

        // ch1 auto-reload, limit 2: period 8, ack behaviour.
        enable = 2'b10; auto_reload = 2'b10; limit = {8'd2, 8'd0}; warn_lvl = '0;
        wait_pulse(1, t0, ok);
        chk("ar_first_seen", ok, 1);
        chk("ar_to1_set", timeout[1], 1);
        chk("ar_any_set", any_to, 1);
        ack[1] = 1'b1; step(); ack[1] = 1'b0;
        chk("ar_ack_clear", timeout[1], 0);
        chk("ar_ack_any", any_to, 0);
        wait_pulse(1, t1, ok);
        chk("ar_period1", t1 - t0, 8);
        chk("ar_to1_reset", timeout[1], 1);
        wait_pulse(1, t2, ok);
        chk("ar_period2", t2 - t1, 8);
        for (int c = 0; c < 10 && cyc < t2 + 7; c++) step();
        ack[1] = 1'b1; step(); ack[1] = 1'b0;
        chk("ar_coinc_pulse", pulse[1], 1);
        chk("ar_coinc_to1", timeout[1], 1);

        // Disable ch0 mid-count; ch1 keeps running.
        enable = 2'b11; limit = {8'd2, 8'd10}; auto_reload = 2'b10;
        for (int c = 0; c < 12; c++) step();
        chk("mid_cnt0_nonzero", (count[7:0] != 0) ? 1 : 0, 1);
        for (int c = 0; c < 4 && tick; c++) step();
        c1 = count[15:8];
        enable = 2'b10;
        step();
        chk("mid_cnt0_clr", count[7:0], 0);
        chk("mid_warn0_clr", warn[0], 0);
        chk("mid_to0_clr", timeout[0], 0);
        chk("mid_cnt1_kept", count[15:8], c1);
        wait_pulse(1, t0, ok);
        chk("mid_ch1_runs", ok, 1);

        // Reset mid-count: everything clears, no pulses.
        enable = 2'b11;
        for (int c = 0; c < 6; c++) step();
        rst = 1'b1; pulses = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (pulse != 0) pulses++;
        end
        chk("rst_mid_pulses", pulses, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_timeout", timeout, 0);
        chk("rst_mid_any", any_to, 0);
        chk("rst_mid_tick", tick, 0);
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
